// File: rtl/uart_frame_rx.sv
// uart_frame_rx: two-byte UART frame receiver ({command, address}) with inter-byte timeout.
// Define UART_PARITY_EN to expect an even-parity bit after bit 7 of each byte.
module uart_frame_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = CPB > 2 ? $clog2(CPB) : 1;
  localparam int GW  = $clog2(TIMEOUT_BITS + 1);
`ifdef UART_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  state_t          state;
  logic            rx_s1, rx_s2, rx_q;
  logic [CW-1:0]   cnt;
  logic [3:0]      idx;
  logic [GW-1:0]   gap;
  logic [NB-1:0]   sh;
  logic [7:0]      byte0;
  logic            second, hold;
  logic            fall, tick, good;
  assign fall = rx_q & ~rx_s2;
  assign tick = cnt == LAST;
`ifdef UART_PARITY_EN
  assign good = rx_s2 & ~^sh;
`else
  assign good = rx_s2;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_q        <= 1'b1;
      cnt         <= '0;
      idx         <= '0;
      gap         <= '0;
      sh          <= '0;
      byte0       <= '0;
      second      <= 1'b0;
      hold        <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      rx_q        <= rx_s2;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      cnt         <= tick ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state  <= START;
            busy   <= 1'b1;
            second <= 1'b0;
          end
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          idx <= '0;
          if (rx_s2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else state <= DATA;
        end
        DATA: if (tick) begin
          sh  <= {rx_s2, sh[NB-1:1]};
          idx <= idx + 4'd1;
          if (idx == 4'(NB - 1)) state <= STOP;
        end
        STOP: if (hold) begin
          // after a bad byte, stay here until the line is back high
          cnt <= '0;
          if (rx_s2) begin
            hold  <= 1'b0;
            state <= IDLE;
          end
        end else if (tick) begin
          if (!good) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            hold      <= 1'b1;
          end else if (second) begin
            frame       <= {byte0, sh[7:0]};
            frame_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            byte0 <= sh[7:0];
            gap   <= '0;
            state <= GAP;
          end
        end
        GAP: if (fall) begin
          state  <= START;
          cnt    <= '0;
          second <= 1'b1;
        end else if (tick) begin
          gap <= gap + 1'b1;
          if (gap == GW'(TIMEOUT_BITS - 1)) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
